// File: rtl/ahb_apb_pkg.sv
// Shared types and bus encodings for the AHB-Lite to APB3 multi-slot bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/apb_slot_mux.sv
// Slot index decode to one-hot select, plus AND-OR selection of the addressed
// slave's PRDATA/PREADY/PSLVERR. An index with no slave yields all zeros.
module apb_slot_mux #(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_W    = 32,
  parameter int SW        = 2
) (
  input  logic [SW-1:0]             slot,
  input  logic [NUM_SLOTS*DATA_W-1:0] prdata,
  input  logic [NUM_SLOTS-1:0]      pready,
  input  logic [NUM_SLOTS-1:0]      pslverr,
  output logic [NUM_SLOTS-1:0]      sel_onehot,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      slverr
);

  // Decode and select in one pass over the slots.
  always_comb begin
    sel_onehot = '0;
    rdata      = '0;
    ready      = 1'b0;
    slverr     = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      sel_onehot[s] = (slot == SW'(s));
      rdata  = rdata | (prdata[s*DATA_W +: DATA_W] & {DATA_W{sel_onehot[s]}});
      ready  = ready | (pready[s] & sel_onehot[s]);
      slverr = slverr | (pslverr[s] & sel_onehot[s]);
    end
  end

endmodule

// File: rtl/ahb_apb3_bridge_mslot.sv
// AHB-Lite slave to APB3 master bridge with NUM_SLOTS decoded slaves, PREADY
// timeout and ERROR response on PSLVERR, timeout or unmapped slot.
module ahb_apb3_bridge_mslot
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_AW   = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                        HCLK,
  input  logic                        HRESETN,
  input  logic                        HSEL,
  input  logic [ADDR_W-1:0]           HADDR,
  input  logic [1:0]                  HTRANS,
  input  logic                        HWRITE,
  input  logic [DATA_W-1:0]           HWDATA,
  input  logic                        HREADY,
  output logic [DATA_W-1:0]           HRDATA,
  output logic                        HREADYOUT,
  output logic [1:0]                  HRESP,
  output logic [ADDR_W-1:0]           PADDR,
  output logic [NUM_SLOTS-1:0]        PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  input  logic [NUM_SLOTS*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLOTS-1:0]        PREADY,
  input  logic [NUM_SLOTS-1:0]        PSLVERR
);

  localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW:0]    SLOTS_LIM = (SW+1)'(NUM_SLOTS);
  localparam logic [TCW-1:0] TCNT_LIM  = TCW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit             TO_EN     = (TIMEOUT > 0);

  bridge_state_e state_r, state_nxt_s;

  logic [ADDR_W-1:0]    addr_r, addr_nxt_s;
  logic                 write_r, write_nxt_s;
  logic [SW-1:0]        slot_r, slot_nxt_s;
  logic [TCW-1:0]       tcnt_r, tcnt_nxt_s;
  logic [DATA_W-1:0]    hrdata_r, hrdata_nxt_s;
  logic                 hreadyout_r, hreadyout_nxt_s;
  logic [1:0]           hresp_r, hresp_nxt_s;
  logic [ADDR_W-1:0]    paddr_r, paddr_nxt_s;
  logic [NUM_SLOTS-1:0] psel_r, psel_nxt_s;
  logic                 penable_r, penable_nxt_s;
  logic                 pwrite_r, pwrite_nxt_s;
  logic [DATA_W-1:0]    pwdata_r, pwdata_nxt_s;

  logic                 accept_s;
  logic                 slot_mapped_s;
  logic [NUM_SLOTS-1:0] sel_onehot_s;
  logic [DATA_W-1:0]    rdata_s;
  logic                 ready_s;
  logic                 slverr_s;

  assign accept_s      = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign slot_mapped_s = ({1'b0, slot_r} < SLOTS_LIM);

  apb_slot_mux #(
    .NUM_SLOTS (NUM_SLOTS),
    .DATA_W    (DATA_W),
    .SW        (SW)
  ) u_slot_mux (
    .slot       (slot_r),
    .prdata     (PRDATA),
    .pready     (PREADY),
    .pslverr    (PSLVERR),
    .sel_onehot (sel_onehot_s),
    .rdata      (rdata_s),
    .ready      (ready_s),
    .slverr     (slverr_s)
  );

  // Next state and next value of every registered output.
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    write_nxt_s     = write_r;
    slot_nxt_s      = slot_r;
    tcnt_nxt_s      = tcnt_r;
    hrdata_nxt_s    = hrdata_r;
    hreadyout_nxt_s = hreadyout_r;
    hresp_nxt_s     = hresp_r;
    paddr_nxt_s     = paddr_r;
    psel_nxt_s      = psel_r;
    penable_nxt_s   = penable_r;
    pwrite_nxt_s    = pwrite_r;
    pwdata_nxt_s    = pwdata_r;
    case (state_r)
      ST_IDLE: begin
        hresp_nxt_s = HRESP_OKAY;
        if (accept_s) begin
          state_nxt_s     = ST_WAIT;
          hreadyout_nxt_s = 1'b0;
          addr_nxt_s      = HADDR;
          write_nxt_s     = HWRITE;
          slot_nxt_s      = HADDR[SLOT_AW +: SW];
        end else begin
          hreadyout_nxt_s = 1'b1;
        end
      end
      ST_WAIT: begin
        // APB-side signals only change when a real APB cycle follows.
        if (slot_mapped_s) begin
          state_nxt_s  = ST_SETUP;
          psel_nxt_s   = sel_onehot_s;
          paddr_nxt_s  = addr_r;
          pwrite_nxt_s = write_r;
          pwdata_nxt_s = HWDATA;
        end else begin
          state_nxt_s = ST_ERR1;
          hresp_nxt_s = HRESP_ERROR;
        end
      end
      ST_SETUP: begin
        state_nxt_s   = ST_ACCESS;
        penable_nxt_s = 1'b1;
        tcnt_nxt_s    = '0;
      end
      ST_ACCESS: begin
        if (ready_s) begin
          psel_nxt_s    = '0;
          penable_nxt_s = 1'b0;
          if (!write_r) begin
            hrdata_nxt_s = rdata_s;
          end else begin
            hrdata_nxt_s = hrdata_r;
          end
          if (slverr_s) begin
            state_nxt_s = ST_ERR1;
            hresp_nxt_s = HRESP_ERROR;
          end else begin
            state_nxt_s     = ST_IDLE;
            hreadyout_nxt_s = 1'b1;
          end
        end else if (TO_EN && (tcnt_r == TCNT_LIM)) begin
          psel_nxt_s    = '0;
          penable_nxt_s = 1'b0;
          state_nxt_s   = ST_ERR1;
          hresp_nxt_s   = HRESP_ERROR;
        end else begin
          tcnt_nxt_s = tcnt_r + TCW'(1);
        end
      end
      ST_ERR1: begin
        state_nxt_s     = ST_ERR2;
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_ERROR;
      end
      ST_ERR2: begin
        state_nxt_s     = ST_IDLE;
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_OKAY;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_OKAY;
        psel_nxt_s      = '0;
        penable_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transfer context and registered bus outputs.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      addr_r      <= '0;
      write_r     <= 1'b0;
      slot_r      <= '0;
      tcnt_r      <= '0;
      hrdata_r    <= '0;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
      paddr_r     <= '0;
      psel_r      <= '0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      pwdata_r    <= '0;
    end else begin
      addr_r      <= addr_nxt_s;
      write_r     <= write_nxt_s;
      slot_r      <= slot_nxt_s;
      tcnt_r      <= tcnt_nxt_s;
      hrdata_r    <= hrdata_nxt_s;
      hreadyout_r <= hreadyout_nxt_s;
      hresp_r     <= hresp_nxt_s;
      paddr_r     <= paddr_nxt_s;
      psel_r      <= psel_nxt_s;
      penable_r   <= penable_nxt_s;
      pwrite_r    <= pwrite_nxt_s;
      pwdata_r    <= pwdata_nxt_s;
    end
  end

  assign HRDATA    = hrdata_r;
  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;
  assign PADDR     = paddr_r;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PWDATA    = pwdata_r;

endmodule
